// File: rtl/vga_line_fetch.sv
// Scans a low-res framebuffer onto the 640x480 raster through a ping-pong line buffer.
// Rows are prefetched during v-sync/h-blank; RGB is registered two clk behind pix_x.
module vga_line_fetch #(
  parameter int SCALE_LOG2 = 2,
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              available,
  input  logic              v_sync,
  input  logic [15:0]       pix_x,
  input  logic [15:0]       pix_y,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] rgb,
  output logic              rgb_valid,
  output logic              underrun
);

  localparam int COL_W    = $clog2(FB_W);
  localparam int ROW_W    = $clog2(FB_H);
  localparam int H_ACTIVE = 640;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  logic [DATA_W-1:0] lb [2][FB_W];

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d, wr_col_q, wr_col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d, mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d, wr_vld_q, wr_vld_d;
  logic              sel_q, sel_d, ready_q, ready_d, line_ok_q, line_ok_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] pix_q, pix_d, rgb_q, rgb_d;
  logic              v1_q, v1_d, rgb_valid_q, rgb_valid_d;
  logic              available_q, v_sync_q;

  logic                  v_rise, a_rise, a_fall, row_trig, swap_line;
  logic [SCALE_LOG2-1:0] y_next_lo;
  logic [COL_W-1:0]      rd_idx;

  always_comb begin
    v_rise    = v_sync & ~v_sync_q;
    a_rise    = available & ~available_q;
    a_fall    = ~available & available_q;
    y_next_lo = pix_y[SCALE_LOG2-1:0] + SCALE_LOG2'(1);
    row_trig  = a_fall && (y_next_lo == '0) && (row_q != ROW_W'(FB_H - 1));
    swap_line = a_rise && (pix_y[SCALE_LOG2-1:0] == '0);
    rd_idx    = (pix_x >= 16'(H_ACTIVE)) ? '0 : COL_W'(pix_x >> SCALE_LOG2);

    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    base_d     = base_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    sel_d      = sel_q;
    ready_d    = ready_q;
    line_ok_d  = line_ok_q;
    underrun_d = underrun_q;
    wr_vld_d   = mem_rd_q;
    wr_col_d   = col_q;

    case (state_q)
      IDLE: begin
        if (v_rise) begin
          row_d      = '0;
          base_d     = '0;
          state_d    = FETCH;
          col_d      = '0;
          mem_rd_d   = 1'b1;
          mem_addr_d = '0;
        end else if (row_trig) begin
          row_d      = row_q + ROW_W'(1);
          base_d     = base_q + ADDR_W'(FB_W);
          state_d    = FETCH;
          col_d      = '0;
          mem_rd_d   = 1'b1;
          mem_addr_d = base_q + ADDR_W'(FB_W);
        end
      end
      FETCH: begin
        if (col_q == COL_W'(FB_W - 1)) begin
          state_d  = DRAIN;
          mem_rd_d = 1'b0;
        end else begin
          col_d      = col_q + COL_W'(1);
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if ((v_rise || row_trig) && state_q != IDLE) underrun_d = 1'b1;

    // A row finishing in this very clk counts as ready; the swap consumes it.
    if (swap_line) begin
      if (ready_q || state_q == DRAIN) begin
        sel_d     = ~sel_q;
        ready_d   = 1'b0;
        line_ok_d = 1'b1;
      end else begin
        underrun_d = 1'b1;
        line_ok_d  = 1'b0;
      end
    end

    pix_d       = lb[sel_d][rd_idx];
    v1_d        = available;
    rgb_d       = (v1_q && line_ok_q) ? pix_q : '0;
    rgb_valid_d = v1_q;
  end

  always_ff @(posedge clk) begin
    available_q <= available;
    v_sync_q    <= v_sync;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      base_q      <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      wr_vld_q    <= 1'b0;
      wr_col_q    <= '0;
      sel_q       <= 1'b0;
      ready_q     <= 1'b0;
      line_ok_q   <= 1'b0;
      underrun_q  <= 1'b0;
      pix_q       <= '0;
      v1_q        <= 1'b0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      base_q      <= base_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      wr_vld_q    <= wr_vld_d;
      wr_col_q    <= wr_col_d;
      sel_q       <= sel_d;
      ready_q     <= ready_d;
      line_ok_q   <= line_ok_d;
      underrun_q  <= underrun_d;
      pix_q       <= pix_d;
      v1_q        <= v1_d;
      rgb_q       <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
    end
  end

  // Read data lands one clk after the strobe, into the buffer not being displayed.
  always_ff @(posedge clk) begin
    if (!rst && wr_vld_q) lb[~sel_q][wr_col_q] <= mem_data;
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign rgb       = rgb_q;
  assign rgb_valid = rgb_valid_q;
  assign underrun  = underrun_q;

endmodule
